// File: rtl/md_sched_pkg.sv
// Shared types and default widths for the home-cell reference scheduler.
package md_sched_pkg;

    localparam int unsigned DEF_PARTICLE_ID_WIDTH = 7;
    localparam int unsigned DEF_RD_LATENCY        = 1;
    localparam int unsigned DRAIN_CNT_W           = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ_NUM,
        WAIT_NUM,
        SWEEP,
        DRAIN,
        SWAP,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rd_latency_pipe.sv
// Delays the issued read {rd_en, rd_addr} by the memory read latency so the
// returned data can be tagged with its address and the count-word flag.
module rd_latency_pipe
    import md_sched_pkg::*;
#(
    parameter int unsigned PARTICLE_ID_WIDTH = DEF_PARTICLE_ID_WIDTH,
    parameter int unsigned RD_LATENCY        = DEF_RD_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_en,
    input  logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic                         reading_particle_num
);

    localparam int unsigned LAST = RD_LATENCY - 1;

    logic                         en_q   [RD_LATENCY];
    logic                         zero_q [RD_LATENCY];
    logic [PARTICLE_ID_WIDTH-1:0] addr_q [RD_LATENCY];

    // The final address stage only loads on a valid read, so particle_id holds
    // the last returned address while no read is coming back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                en_q[i]   <= 1'b0;
                zero_q[i] <= 1'b0;
                addr_q[i] <= '0;
            end
        end else begin
            en_q[0]   <= rd_en;
            zero_q[0] <= rd_en && (rd_addr == '0);
            if (LAST != 0 || rd_en) begin
                addr_q[0] <= rd_addr;
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                en_q[i]   <= en_q[i-1];
                zero_q[i] <= zero_q[i-1];
                if (i != int'(LAST) || en_q[i-1]) begin
                    addr_q[i] <= addr_q[i-1];
                end
            end
        end
    end

    assign particle_id          = addr_q[LAST];
    assign reading_particle_num = zero_q[LAST];

endmodule

// File: rtl/ref_sched_ctrl.sv
// Home-cell evaluation scheduler: reads the particle count, then sweeps all N
// home particles once per reference particle, alternating the phase bit.
module ref_sched_ctrl
    import md_sched_pkg::*;
#(
    parameter int unsigned PARTICLE_ID_WIDTH = DEF_PARTICLE_ID_WIDTH,
    parameter int unsigned RD_LATENCY        = DEF_RD_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stall,
    input  logic [PARTICLE_ID_WIDTH-1:0] count_in,
    output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    output logic                         rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic                         reading_particle_num,
    output logic                         phase,
    output logic                         prev_phase,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned W = PARTICLE_ID_WIDTH;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(RD_LATENCY - 1);

    sched_state_t            state, state_nxt;
    logic [W-1:0]            rd_addr_nxt, next_addr, next_addr_nxt;
    logic [W-1:0]            ref_id_nxt, count_nxt;
    logic                    rd_en_nxt, phase_nxt, busy_nxt, done_nxt;
    logic [DRAIN_CNT_W-1:0]  drain_cnt, drain_cnt_nxt;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            rd_addr            <= '0;
            rd_en              <= 1'b0;
            next_addr          <= '0;
            phase              <= 1'b0;
            prev_phase         <= 1'b0;
            ref_id             <= '0;
            ref_particle_count <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            drain_cnt          <= '0;
        end else begin
            state              <= state_nxt;
            rd_addr            <= rd_addr_nxt;
            rd_en              <= rd_en_nxt;
            next_addr          <= next_addr_nxt;
            phase              <= phase_nxt;
            prev_phase         <= phase;
            ref_id             <= ref_id_nxt;
            ref_particle_count <= count_nxt;
            busy               <= busy_nxt;
            done               <= done_nxt;
            drain_cnt          <= drain_cnt_nxt;
        end
    end

    // next_addr is the address the sweep will issue on its next unstalled cycle.
    always_comb begin
        state_nxt     = state;
        rd_addr_nxt   = rd_addr;
        rd_en_nxt     = 1'b0;
        next_addr_nxt = next_addr;
        phase_nxt     = phase;
        ref_id_nxt    = ref_id;
        count_nxt     = ref_particle_count;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        drain_cnt_nxt = drain_cnt;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = READ_NUM;
                    busy_nxt    = 1'b1;
                    phase_nxt   = 1'b0;
                    ref_id_nxt  = W'(1);
                    rd_addr_nxt = '0;
                end
            end
            READ_NUM: begin
                if (!stall) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                    state_nxt   = WAIT_NUM;
                end
            end
            WAIT_NUM: begin
                if (reading_particle_num) begin
                    count_nxt = count_in;
                    if (count_in == '0) begin
                        ref_id_nxt = '0;
                        done_nxt   = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        rd_addr_nxt   = W'(1);
                        next_addr_nxt = W'(1);
                        state_nxt     = SWEEP;
                    end
                end
            end
            SWEEP: begin
                if (!stall) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = next_addr;
                    if (next_addr == ref_particle_count) begin
                        drain_cnt_nxt = '0;
                        state_nxt     = DRAIN;
                    end else begin
                        next_addr_nxt = next_addr + W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    if (ref_id == ref_particle_count) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SWAP;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt + DRAIN_CNT_W'(1);
                end
            end
            SWAP: begin
                phase_nxt     = ~phase;
                ref_id_nxt    = ref_id + W'(1);
                rd_addr_nxt   = W'(1);
                next_addr_nxt = W'(1);
                state_nxt     = SWEEP;
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    rd_latency_pipe #(
        .PARTICLE_ID_WIDTH (PARTICLE_ID_WIDTH),
        .RD_LATENCY        (RD_LATENCY)
    ) u_rd_latency_pipe (
        .clk                  (clk),
        .rst                  (rst),
        .rd_en                (rd_en),
        .rd_addr              (rd_addr),
        .particle_id          (particle_id),
        .reading_particle_num (reading_particle_num)
    );

endmodule
